// File: rtl/alu_logic_pipe_pkg.sv
// alu_logic_pipe_pkg
//   Shared datapath constants for the ALU logic unit: the register width
//   and the 4-bit operation-select encoding. AND..SLT keep the codes they
//   had in the earlier 3-bit encoding. Codes above ALU_PASSB are illegal.
//   No ports; imported by the interface, the core and the pipeline top.
package alu_logic_pipe_pkg;

    localparam int REG_WIDTH   = 32;
    localparam int ALU_OPSEL_W = 4;

    typedef enum logic [ALU_OPSEL_W-1:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_NOR   = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_SLT   = 4'd4,
        ALU_SLTU  = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_PASSB = 4'd9
    } alu_op_e;

    // Every code up to and including PASSB is defined; 10..15 are not.
    function automatic logic is_legal_op(input logic [ALU_OPSEL_W-1:0] opsel);
        return opsel <= ALU_PASSB;
    endfunction

endpackage

// File: rtl/alu_logic_pipe_if.sv
// alu_logic_pipe_if
//   Valid/ready operation bus into and out of the pipelined ALU logic unit.
//   master : the side that issues operations and consumes results
//            (drives in_valid, op_a, op_b, log_opsel, out_ready).
//   slave  : the ALU pipeline itself
//            (drives in_ready, out_valid, result, zero, illegal).
interface alu_logic_pipe_if
    import alu_logic_pipe_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [ALU_OPSEL_W-1:0] log_opsel;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       result;
    logic                   zero;
    logic                   illegal;

    modport master (
        output in_valid, op_a, op_b, log_opsel, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, op_a, op_b, log_opsel, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

endinterface

// File: rtl/alu_logic_pipe_core.sv
// alu_logic_core
//   Purely combinational bitwise / compare / shift evaluator.
//   Ports:
//     op_a, op_b  in  WIDTH  operands (shifts use op_b[SHW-1:0] only)
//     log_opsel   in  4      operation select
//     result      out WIDTH  operation result (0 for illegal codes)
//     illegal     out 1      log_opsel is not a defined code
module alu_logic_core
    import alu_logic_pipe_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic [WIDTH-1:0]       op_a,
    input  logic [WIDTH-1:0]       op_b,
    input  logic [ALU_OPSEL_W-1:0] log_opsel,
    output logic [WIDTH-1:0]       result,
    output logic                   illegal
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SHW-1:0]   shamt;

    assign a_s   = op_a;
    assign b_s   = op_b;
    // Only the low SHW bits select the amount, so it can never reach WIDTH.
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        result  = '0;
        illegal = !is_legal_op(log_opsel);
        case (log_opsel)
            ALU_AND:   result = op_a & op_b;
            ALU_OR:    result = op_a | op_b;
            ALU_NOR:   result = ~(op_a | op_b);
            ALU_XOR:   result = op_a ^ op_b;
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:   result = op_a << shamt;
            ALU_SRL:   result = op_a >> shamt;
            // a_s is signed, so >>> replicates op_a[WIDTH-1].
            ALU_SRA:   result = a_s >>> shamt;
            ALU_PASSB: result = op_b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe
//   Two-stage pipelined ALU logic unit with valid/ready flow control.
//   S1 registers the operands and opcode; alu_logic_core evaluates them and
//   S2 registers result, zero and illegal. Each stage has its own valid bit
//   and holds its contents while its enable is low.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset (clears both valid bits)
//     bus    alu_logic_pipe_if.slave: in_valid/in_ready/op_a/op_b/log_opsel
//            on the issue side, out_valid/out_ready/result/zero/illegal on
//            the writeback side
module alu_logic_pipe
    import alu_logic_pipe_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_logic_pipe_if.slave    bus
);

    logic                   vld_p1;
    logic                   vld_p2;
    logic                   s1_en;
    logic                   s2_en;

    logic [WIDTH-1:0]       a_p1;
    logic [WIDTH-1:0]       b_p1;
    logic [ALU_OPSEL_W-1:0] opsel_p1;

    logic [WIDTH-1:0]       core_result;
    logic                   core_illegal;

    logic [WIDTH-1:0]       result_p2;
    logic                   zero_p2;
    logic                   illegal_p2;

    // A stage may load when it is empty or when its contents move on this
    // edge. in_ready depends only on state and out_ready, never on in_valid.
    assign s2_en        = !vld_p2 || bus.out_ready;
    assign s1_en        = !vld_p1 || s2_en;
    assign bus.in_ready = s1_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_en) begin
                vld_p1 <= bus.in_valid;
            end
            if (s2_en) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // ---- S1: operand / opcode capture ----
    always_ff @(posedge clk) begin
        if (s1_en && bus.in_valid) begin
            a_p1     <= bus.op_a;
            b_p1     <= bus.op_b;
            opsel_p1 <= bus.log_opsel;
        end
    end

    alu_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_a      (a_p1),
        .op_b      (b_p1),
        .log_opsel (opsel_p1),
        .result    (core_result),
        .illegal   (core_illegal)
    );

    // ---- S2: result / status capture ----
    // Output registers are reset so the bus shows zeros until the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p2  <= '0;
            zero_p2    <= 1'b0;
            illegal_p2 <= 1'b0;
        end else if (s2_en && vld_p1) begin
            result_p2  <= core_result;
            zero_p2    <= (core_result == '0);
            illegal_p2 <= core_illegal;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.result    = result_p2;
    assign bus.zero      = zero_p2;
    assign bus.illegal   = illegal_p2;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// tb_alu_logic_pipe
//   Directed bench for alu_logic_pipe at WIDTH 32 and WIDTH 8. An
//   arithmetic reference model feeds a per-instance queue of expected
//   results that one negedge process compares with every output transfer,
//   and also checks that stalled outputs do not move.
module tb_alu_logic_pipe;

    logic clk;
    logic rst_n;

    int total;
    int bad;
    int rcv32;
    int rcv8;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t ce;

    logic        hold32;
    logic        hold8;
    logic [33:0] held32;
    logic [9:0]  held8;

    alu_logic_pipe_if #(.WIDTH(32)) b32 ();
    alu_logic_pipe_if #(.WIDTH(8))  b8 ();

    alu_logic_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_logic_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model: operates on w-bit values held in 64-bit containers.
    function automatic exp_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input int op, input int w);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        int          n;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = $signed(a);
        sb   = $signed(b);
        if (a[w-1]) sa = sa - $signed(64'd1 << w);
        if (b[w-1]) sb = sb - $signed(64'd1 << w);
        n     = int'(b % 64'(w));
        e.ill = 1'b0;
        case (op)
            0:       e.res = a & b;
            1:       e.res = a | b;
            2:       e.res = ~(a | b) & mask;
            3:       e.res = a ^ b;
            4:       e.res = (sa < sb) ? 64'd1 : 64'd0;
            5:       e.res = (a < b) ? 64'd1 : 64'd0;
            6:       e.res = (a << n) & mask;
            7:       e.res = a >> n;
            8:       e.res = 64'(sa >>> n) & mask;
            9:       e.res = b;
            default: begin e.res = 64'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    // Scoreboard and stall-stability checks for both instances.
    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            q8.delete();
            hold32 = 1'b0;
            hold8  = 1'b0;
        end else begin
            if (hold32) begin
                check("stall_valid32", 64'(b32.out_valid), 64'd1);
                check("stall_data32", 64'({b32.result, b32.zero, b32.illegal}), 64'(held32));
            end
            if (b32.out_valid && b32.out_ready) begin
                rcv32++;
                if (q32.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out32: result %h with nothing pending", b32.result);
                end else begin
                    ce = q32.pop_front();
                    check("result32", 64'(b32.result), ce.res);
                    check("zero32", 64'(b32.zero), 64'(ce.zero));
                    check("illegal32", 64'(b32.illegal), 64'(ce.ill));
                end
            end
            hold32 = b32.out_valid && !b32.out_ready;
            held32 = {b32.result, b32.zero, b32.illegal};
            if (b32.in_valid && b32.in_ready)
                q32.push_back(model(64'(b32.op_a), 64'(b32.op_b), int'(b32.log_opsel), 32));

            if (hold8) begin
                check("stall_valid8", 64'(b8.out_valid), 64'd1);
                check("stall_data8", 64'({b8.result, b8.zero, b8.illegal}), 64'(held8));
            end
            if (b8.out_valid && b8.out_ready) begin
                rcv8++;
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out8: result %h with nothing pending", b8.result);
                end else begin
                    ce = q8.pop_front();
                    check("result8", 64'(b8.result), ce.res);
                    check("zero8", 64'(b8.zero), 64'(ce.zero));
                    check("illegal8", 64'(b8.illegal), 64'(ce.ill));
                end
            end
            hold8 = b8.out_valid && !b8.out_ready;
            held8 = {b8.result, b8.zero, b8.illegal};
            if (b8.in_valid && b8.in_ready)
                q8.push_back(model(64'(b8.op_a), 64'(b8.op_b), int'(b8.log_opsel), 8));
        end
    end

    // One op into an empty pipe: presented in cycle 0, visible in cycle 2.
    // Call at posedge+1.
    task automatic single32(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] er,
                            input logic ez, input logic ei);
        exp_t m;
        m = model(64'(a), 64'(b), int'(op), 32);
        check({name, "_model"}, m.res, 64'(er));
        b32.out_ready = 1'b1;
        b32.op_a      = a;
        b32.op_b      = b;
        b32.log_opsel = op;
        b32.in_valid  = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check({name, "_early"}, 64'(b32.out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, 64'(b32.out_valid), 64'd1);
        check({name, "_result"}, 64'(b32.result), 64'(er));
        check({name, "_zero"}, 64'(b32.zero), 64'(ez));
        check({name, "_illegal"}, 64'(b32.illegal), 64'(ei));
        @(posedge clk); #1;
    endtask

    task automatic single8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [7:0] er);
        exp_t m;
        m = model(64'(a), 64'(b), int'(op), 8);
        check({name, "_model"}, m.res, 64'(er));
        b8.out_ready = 1'b1;
        b8.op_a      = a;
        b8.op_b      = b;
        b8.log_opsel = op;
        b8.in_valid  = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_valid"}, 64'(b8.out_valid), 64'd1);
        check({name, "_result"}, 64'(b8.result), 64'(er));
        @(posedge clk); #1;
    endtask

    // Back-to-back issue of n ops; call at posedge+1.
    task automatic stream32(input int n, input int seed, output int sent);
        int guard;
        sent = 0;
        for (int i = 0; i < n; i++) begin
            b32.in_valid  = 1'b1;
            b32.op_a      = 32'(64'h9E37_79B9 * 64'(i + seed + 1));
            b32.op_b      = (i % 2 == 0) ? 32'(i * 5 + seed) : ~b32.op_a;
            b32.log_opsel = 4'((i * 3 + seed) % 11);
            guard = 0;
            @(negedge clk);
            while (!b32.in_ready && guard < 50) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 50) begin
                fail_timeout("stream_accept");
                b32.in_valid = 1'b0;
                return;
            end
            sent++;
            @(posedge clk); #1;
        end
        b32.in_valid = 1'b0;
    endtask

    task automatic drain32(input string name);
        int k;
        k = 0;
        while ((q32.size() != 0 || b32.out_valid) && k < 60) begin
            k++;
            @(negedge clk);
        end
        if (k >= 60) fail_timeout(name);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int rcv0;
        int lat;
        int run;

        total = 0; bad = 0; rcv32 = 0; rcv8 = 0;
        hold32 = 1'b0; hold8 = 1'b0;
        b32.in_valid = 1'b0; b32.out_ready = 1'b0;
        b32.op_a = '0; b32.op_b = '0; b32.log_opsel = '0;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        b8.op_a = '0; b8.op_b = '0; b8.log_opsel = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_result", 64'(b32.result), 64'd0);
        check("rst_zero", 64'(b32.zero), 64'd0);
        check("rst_illegal", 64'(b32.illegal), 64'd0);
        check("rst_out_valid8", 64'(b8.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;

        // Single operations, WIDTH 32.
        single32("and",     32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0, 32'h00F0_00F0, 1'b0, 1'b0);
        single32("xor_self",32'h1234_5678, 32'h1234_5678, 4'd3, 32'h0000_0000, 1'b1, 1'b0);
        single32("slt_m1",  32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'h0000_0001, 1'b0, 1'b0);
        single32("sltu_m1", 32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 32'h0000_0000, 1'b1, 1'b0);
        single32("slt_min", 32'h8000_0000, 32'h0000_0000, 4'd4, 32'h0000_0001, 1'b0, 1'b0);
        single32("sltu_min",32'h8000_0000, 32'h0000_0000, 4'd5, 32'h0000_0000, 1'b1, 1'b0);
        single32("sra4",    32'h8000_0000, 32'h0000_0004, 4'd8, 32'hF800_0000, 1'b0, 1'b0);
        single32("srl4",    32'h8000_0000, 32'h0000_0004, 4'd7, 32'h0800_0000, 1'b0, 1'b0);
        single32("sll31",   32'h0000_0001, 32'h0000_001F, 4'd6, 32'h8000_0000, 1'b0, 1'b0);
        single32("sll0",    32'hA5A5_0F0F, 32'h0000_0000, 4'd6, 32'hA5A5_0F0F, 1'b0, 1'b0);
        single32("sra_b32", 32'h8000_00F0, 32'h0000_0020, 4'd8, 32'h8000_00F0, 1'b0, 1'b0);
        single32("srl_b36", 32'hF000_0000, 32'h0000_0024, 4'd7, 32'h0F00_0000, 1'b0, 1'b0);
        single32("nor0",    32'h0000_0000, 32'h0000_0000, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single32("passb",   32'h1111_1111, 32'hDEAD_BEEF, 4'd9, 32'hDEAD_BEEF, 1'b0, 1'b0);
        single32("illegal12",32'hFFFF_FFFF,32'h0000_0001, 4'd12,32'h0000_0000, 1'b1, 1'b1);
        single32("or_after",32'h0000_0001, 32'h0000_0002, 4'd1, 32'h0000_0003, 1'b0, 1'b0);

        // Backpressure: out_ready low for 5 edges mid-stream.
        rcv0 = rcv32;
        b32.out_ready = 1'b1;
        fork
            stream32(8, 1, sent);
            begin
                repeat (3) @(posedge clk);
                #1 b32.out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
                check("bp_out_valid", 64'(b32.out_valid), 64'd1);
                repeat (4) @(posedge clk);
                #1 b32.out_ready = 1'b1;
            end
        join
        drain32("bp_drain");
        check("bp_sent", 64'(sent), 64'd8);
        check("bp_received", 64'(rcv32 - rcv0), 64'd8);

        // Full rate: 16 ops, one per cycle in and out.
        rcv0 = rcv32;
        b32.out_ready = 1'b1;
        fork
            stream32(16, 7, sent);
            begin
                lat = 0;
                run = 0;
                @(negedge clk);
                while (!b32.out_valid && lat < 20) begin
                    lat++;
                    @(negedge clk);
                end
                check("fr_latency", 64'(lat), 64'd2);
                while (b32.out_valid && run < 40) begin
                    run++;
                    @(negedge clk);
                end
                check("fr_consecutive", 64'(run), 64'd16);
            end
        join
        drain32("fr_drain");
        check("fr_received", 64'(rcv32 - rcv0), 64'd16);

        // Async reset with both stages holding operations.
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1;
        b32.op_a = 32'h0000_00FF; b32.op_b = 32'h0000_0F0F; b32.log_opsel = 4'd0;
        @(posedge clk); #1;
        b32.op_a = 32'h0000_0001; b32.op_b = 32'h0000_0002; b32.log_opsel = 4'd1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("ar_pre_valid", 64'(b32.out_valid), 64'd1);
        check("ar_pre_in_ready", 64'(b32.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid_cleared", 64'(b32.out_valid), 64'd0);
        check("ar_result_cleared", 64'(b32.result), 64'd0);
        check("ar_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        b32.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ar_no_stale", 64'(b32.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Shift behaviour at WIDTH 8.
        single8("sra8_7",  8'h80, 8'd7, 4'd8, 8'hFF);
        single8("sra8_4",  8'h80, 8'd4, 4'd8, 8'hF8);
        single8("srl8_b9", 8'h80, 8'd9, 4'd7, 8'h40);
        single8("sll8_b9", 8'h81, 8'd9, 4'd6, 8'h02);
        single8("sll8_7",  8'h01, 8'd7, 4'd6, 8'h80);
        single8("slt8",    8'h80, 8'd0, 4'd4, 8'h01);
        single8("sltu8",   8'h80, 8'd0, 4'd5, 8'h00);
        check("w8_received", 64'(rcv8), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
